ifetch_ctrl: RTL
================

// Module: ifetch_ctrl
// PURPOSE
//  Sequences the instruction memory: owns the fetch PC, drives the word-aligned imem read address,
//  and buffers fetched words in a small FIFO toward decode with valid/ready handshake.
//  Sits between instruction_memory (async-read, same-cycle data) and the decode stage;
//  accepts PC redirects (branch/jump/trap) from execute and flushes stale entries.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch PC loaded on reset
//  FIFO_DEPTH  2              fetch buffer entries; power of 2, >=2
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst_n           in   1   asynchronous active-low reset
//  enable          in   1   1 = fetch, 0 = halt fetching (buffer still drains)
//  imem_addr       out  32  byte address to instruction memory (= fetch_pc)
//  imem_rdata      in   32  instruction word, valid same cycle as imem_addr
//  redirect_valid  in   1   load redirect_pc into fetch PC, flush buffer
//  redirect_pc     in   32  new fetch byte address
//  out_valid       out  1   buffer head valid
//  out_ready       in   1   decode accepts head this cycle
//  out_instr       out  32  head instruction
//  out_pc          out  32  byte address of head instruction
//  out_fault       out  1   head is a misaligned-fetch fault marker
// BEHAVIOUR
//  Reset (async assert, sync release): fetch_pc=RESET_PC, state=RUN, FIFO empty; out_valid=0,
//   out_instr=32'h0000_0013, out_pc=0, out_fault=0 (head fields read NOP/0/0 whenever empty).
//  imem_addr = fetch_pc combinationally, every cycle, in every state.
//  States: RUN, HALT, FAULT.
//   RUN  -> HALT when enable=0; HALT -> RUN when enable=1; FAULT exits only via aligned redirect.
//   redirect_valid overrides every state and transition.
//  Push (RUN, enable=1, no redirect): allowed if !full OR (out_valid && out_ready) same cycle;
//   pushes {fetch_pc, imem_rdata, fault=0}; fetch_pc <= fetch_pc+4, wraps mod 2^32.
//   No push -> fetch_pc holds.
//  Pop: out_valid && out_ready removes head. Simultaneous push+pop on full: both occur, count unchanged.
//  Latency: word at fetch_pc appears at out_* the cycle after its push; 1 instr/cycle sustained
//   when out_ready=1 continuously.
//  Redirect (redirect_valid=1), highest priority:
//   - FIFO flushed (count=0, pointers reset); any same-cycle pop and push are discarded.
//   - redirect_pc[1:0]==0: fetch_pc <= redirect_pc, state <= RUN if enable else HALT;
//     first new instruction at out_* 2 cycles after redirect cycle.
//   - redirect_pc[1:0]!=0: state <= FAULT; fetch_pc <= redirect_pc; next cycle FIFO holds exactly
//     one entry {pc=redirect_pc, instr=32'h13, fault=1}; no further pushes while FAULT.
//  FAULT entry pops normally; afterwards out_valid=0 until an aligned redirect.
//  enable=0 mid-stream: pushes stop next edge, buffered entries still drain.
//  Reset mid-operation: all state returns to reset values immediately, no partial pops.
// STRUCTURE
//  riscv_pkg: NOP_INSTR=32'h0000_0013, fetch_entry_t {pc[31:0], instr[31:0], fault},
//   ifetch_state_e {RUN,HALT,FAULT}.
//  Sub-module sync_fifo #(type T=fetch_entry_t, DEPTH): push/pop/flush, full/empty, head out,
//   push-when-full-with-pop allowed. Controller FSM + PC register in ifetch_ctrl.
// TESTING
//  1 Reset, enable=1, out_ready=1, mem[i]=i -> out_pc 0,4,8,.. one per cycle from cycle 2,
//    out_instr 0,1,2,..
//  2 out_ready=0 for 5 cycles -> buffer fills to FIFO_DEPTH, imem_addr holds at 8,
//    no loss/duplication on release.
//  3 redirect_pc=0x100 while buffer full -> stale entries gone, next out_pc=0x100, then 0x104.
//  4 redirect_pc=0x102 -> one entry pc=0x102, instr=0x13, fault=1; then out_valid=0;
//    redirect 0x200 resumes.
//  5 enable=0 mid-stream -> at most FIFO_DEPTH further outputs, imem_addr frozen;
//    enable=1 resumes at next pc.
//  6 rst_n low mid-stream, fetch_pc at 0x40 -> out_valid=0 asynchronously, restart at RESET_PC;
//    wrap 0xFFFF_FFFC -> 0x0.

Source files
------------

// File: rtl/ifetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
//   NOP_INSTR      : instruction presented when the fetch buffer is empty
//   fetch_entry_t  : one fetch-buffer entry {pc, instr, fault}
//   ifetch_state_e : controller states
package ifetch_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } ifetch_state_e;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch controller bus: instruction-memory port, redirect input from execute,
// and valid/ready output toward decode.
//   master : fetch controller side
//   slave  : environment side (imem + execute + decode)
interface ifetch_ctrl_if;
  logic        enable;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  modport master (
    input  enable, imem_rdata, redirect_valid, redirect_pc, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, out_fault
  );

  modport slave (
    output enable, imem_rdata, redirect_valid, redirect_pc, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, out_fault
  );
endinterface

// File: rtl/ifetch_ctrl_fifo.sv
// Synchronous FIFO for fetch entries.
//   clk, rst_n     : clock, async active-low reset
//   i_push/i_data  : write request and data
//   i_pop          : remove head (ignored when empty)
//   i_flush        : discard contents; a same-cycle push becomes the only entry
//   o_head         : head entry (undefined content when empty)
//   o_full/o_empty : occupancy flags
// A push while full is accepted when a pop happens in the same cycle.
module ifetch_ctrl_fifo
  import ifetch_ctrl_pkg::*;
#(
  parameter type T     = fetch_entry_t,
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_flush,
  input  T     i_data,
  output T     o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_wr_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  // A flush empties the buffer, so a push alongside it always has room.
  assign w_do_push = i_push && (i_flush || !o_full || w_do_pop);
  assign w_wr_idx  = i_flush ? '0 : r_wr_ptr;
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[w_wr_idx] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= w_do_push ? AW'(1) : '0;
      r_count  <= w_do_push ? CW'(1) : '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, drives the imem address,
// and buffers fetched words toward decode. Redirects flush the buffer; a
// misaligned redirect yields a single fault marker entry and stalls fetch.
//   clk, rst_n : clock, async active-low reset
//   bus        : ifetch_ctrl_if.master (imem, redirect, decode handshake, enable)
//
// state    | meaning
// ST_RUN   | fetching one word per cycle while buffer has room
// ST_HALT  | enable low, no fetch; buffer drains
// ST_FAULT | misaligned redirect taken; waits for an aligned redirect
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic         clk,
  input logic         rst_n,
  ifetch_ctrl_if.master bus
);

  ifetch_state_e r_state;
  ifetch_state_e w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_full;
  logic          w_empty;
  logic          w_misaligned;
  fetch_entry_t  w_push_data;
  fetch_entry_t  w_head;

  assign w_misaligned = !is_aligned(bus.redirect_pc);
  assign w_pop        = !w_empty && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.redirect_valid) begin
      if (w_misaligned)    w_state_nxt = ST_FAULT;
      else if (bus.enable) w_state_nxt = ST_RUN;
      else                 w_state_nxt = ST_HALT;
    end else begin
      case (r_state)
        ST_RUN:   w_state_nxt = bus.enable ? ST_RUN : ST_HALT;
        ST_HALT:  w_state_nxt = bus.enable ? ST_RUN : ST_HALT;
        ST_FAULT: w_state_nxt = ST_FAULT;
        default:  w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    w_flush        = bus.redirect_valid;
    w_push         = 1'b0;
    w_push_data    = '{pc: r_fetch_pc, instr: bus.imem_rdata, fault: 1'b0};
    w_fetch_pc_nxt = r_fetch_pc;
    if (bus.redirect_valid) begin
      // The fault marker rides in through the flush so it is the sole entry.
      w_push         = w_misaligned;
      w_push_data    = '{pc: bus.redirect_pc, instr: NOP_INSTR, fault: 1'b1};
      w_fetch_pc_nxt = bus.redirect_pc;
    end else if ((r_state == ST_RUN) && bus.enable && (!w_full || w_pop)) begin
      w_push         = 1'b1;
      w_fetch_pc_nxt = r_fetch_pc + 32'd4;
    end
  end

  ifetch_ctrl_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.imem_addr = r_fetch_pc;
  assign bus.out_valid = !w_empty;
  assign bus.out_instr = w_empty ? NOP_INSTR : w_head.instr;
  assign bus.out_pc    = w_empty ? 32'h0     : w_head.pc;
  assign bus.out_fault = w_empty ? 1'b0      : w_head.fault;

endmodule
